xnor_sweep_ctrl: RTL and testbench
==================================

Name: xnor_sweep_ctrl

Overview:
- Sequencer that drives the 3-input XNOR sum-of-products datapath through its full truth table, waits a settle interval per vector, samples F and checks it against the XNOR reference.
- Replaces hand-written delay-stepped stimulus with an on-chip, clocked self-check.
- Sits between a start/abort source (switches or test harness) and the combinational XNOR block; reports pass/fail, error count and a per-vector failure map.

Parameters:
- N_IN, 3, number of datapath inputs; the vector is N_IN bits and 2**N_IN vectors are swept.
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range is 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sweep request; sampled only in IDLE.
- abort  in  1  synchronous abort; honoured in any non-IDLE state.
- dut_f  in  1  F output of the XNOR datapath.
- dut_vec  out  N_IN  registered {A,B,C} drive (MSB = A).
- busy  out  1  high from start acceptance until DONE is entered.
- done  out  1  one-cycle pulse, high during the DONE state.
- res_valid  out  1  results are complete and stable.
- pass  out  1  err_cnt == 0; meaningful only while res_valid = 1.
- err_cnt  out  N_IN+1  number of mismatching vectors.
- fail_map  out  2**N_IN  bit i set when vector value i mismatched.

Behaviour:
- Reset (async, rst_n low): state IDLE; dut_vec, busy, done, res_valid, pass, err_cnt, fail_map all 0; the settle counter is 0.
- States: IDLE, SETTLE, SAMPLE, DONE (encoding in package).
- IDLE:
  - When start = 1 and abort = 0 at the clock edge, the next state is SETTLE.
  - On that edge: dut_vec <= all ones, cnt <= SETTLE_CYCLES-1, busy <= 1, err_cnt <= 0, fail_map <= 0, res_valid <= 0, pass <= 0.
- SETTLE:
  - If cnt != 0, decrement it.
  - If cnt == 0, go to SAMPLE.
  - Each vector is held SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- SAMPLE:
  - exp = ~^dut_vec.
  - If dut_f != exp: err_cnt += 1 and fail_map[dut_vec] <= 1.
  - If dut_vec == 0: go to DONE and set busy <= 0.
  - Otherwise: dut_vec <= dut_vec - 1, cnt <= SETTLE_CYCLES-1, go to SETTLE.
  - The sweep order is therefore descending, 111 down to 000.
- DONE:
  - done = 1 for exactly one cycle.
  - res_valid <= 1; pass <= (err_cnt == 0). err_cnt is already final on DONE entry.
  - dut_vec is held at 0.
  - Next state is IDLE.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0 + 2**N_IN*(SETTLE_CYCLES+1). For the defaults this is 40 edges.
- Results (err_cnt, fail_map, pass, res_valid) hold until the next accepted start or an abort.
- start outside IDLE is ignored. If start is held high, the next sweep is accepted in the IDLE cycle after DONE, giving one IDLE cycle between sweeps.
- abort in SETTLE, SAMPLE or DONE:
  - Next state is IDLE; dut_vec <= 0, busy <= 0, res_valid <= 0.
  - done is not pulsed. If abort coincides with DONE, done still shows 1 for that cycle, but res_valid is forced to 0.
  - abort wins over every same-cycle event.
  - abort in IDLE has no effect, except that start is blocked that cycle.
- err_cnt cannot overflow: its width of N_IN+1 bits holds the maximum of 2**N_IN.
- rst_n asserted mid-sweep: all outputs go to their reset values immediately, without waiting for a clock edge.

Decomposition:
- Package xnor_sweep_pkg holds:
  - state typedef/localparams (ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE);
  - the default N_IN and SETTLE_CYCLES;
  - a function exp_xnor(vec) returning ~^vec.
- One sub-module, settle_timer (load/count-down/zero flag, 8-bit counter, same clk/rst_n). It is instantiated once.
- The FSM and result registers stay in xnor_sweep_ctrl.

Test Plan:
- Good DUT model (F = ~^vec), default parameters, 1-cycle start:
  - dut_vec steps 111, 110, ..., 000, each value held 5 cycles;
  - done pulses once, 40 edges after start;
  - pass = 1, err_cnt = 0, fail_map = 8'h00, res_valid = 1.
- DUT stuck-at-0:
  - err_cnt = 4, fail_map = 8'h69 (vectors 000, 011, 101, 110), pass = 0.
- DUT stuck-at-1:
  - err_cnt = 4, fail_map = 8'h96, pass = 0.
- abort pulsed 12 cycles after start:
  - next cycle: busy = 0, dut_vec = 000, res_valid = 0, no done pulse;
  - a following start completes a clean sweep with pass = 1.
- start held high for 100 cycles:
  - start re-pulses mid-sweep are ignored;
  - back-to-back sweeps with exactly one IDLE cycle between the done pulse and dut_vec returning to 111.
- rst_n driven low mid-SETTLE, between clock edges:
  - all outputs are 0 before the next edge;
  - after release, the block stays in IDLE until start.

Source files
------------

// File: rtl/xnor_sweep_ctrl_pkg.sv
// xnor_sweep_pkg: shared states, default sizing and XNOR reference for the sweep controller
package xnor_sweep_pkg;
  localparam int N_IN_DEF = 3;
  localparam int SETTLE_DEF = 4;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE = 2'd3;
  // Zero padding does not change the reduction, so narrower vectors may be widened to 8 bits.
  function automatic logic exp_xnor(input logic [7:0] vec);
    return ~^vec;
  endfunction
endpackage

// File: rtl/xnor_sweep_ctrl_if.sv
// xnor_sweep_if: control, result and datapath signals of the sweep controller
// master: harness side (drives start/abort/dut_f); slave: controller side (drives vector and results)
interface xnor_sweep_if
  import xnor_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);
  logic start;
  logic abort;
  logic dut_f;
  logic busy;
  logic done;
  logic res_valid;
  logic pass;
  logic [N_IN-1:0] dut_vec;
  logic [N_IN:0] err_cnt;
  logic [2**N_IN-1:0] fail_map;
  modport master(output start, abort, dut_f, input dut_vec, busy, done, res_valid, pass, err_cnt, fail_map);
  modport slave(input start, abort, dut_f, output dut_vec, busy, done, res_valid, pass, err_cnt, fail_map);
endinterface

// File: rtl/xnor_sweep_ctrl_settle_timer.sv
// settle_timer: loadable 8-bit down-counter with zero flag
// clk/rst_n: clock and async active-low reset; load/load_val: preset; en: count down; zero: count is 0
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 8'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/xnor_sweep_ctrl.sv
// xnor_sweep_ctrl: sweeps the XNOR datapath through every input vector and scores its F output
// clk/rst_n: clock and async active-low reset
// bus (slave): start/abort requests, dut_f sample in; dut_vec drive, busy/done/res_valid/pass, err_cnt, fail_map out
module xnor_sweep_ctrl
  import xnor_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input logic clk,
  input logic rst_n,
  xnor_sweep_if.slave bus
);
  localparam logic [N_IN-1:0] V_ONE = N_IN'(1);
  localparam logic [N_IN:0] E_ONE = (N_IN + 1)'(1);
  state_t st;
  logic [N_IN-1:0] vec;
  logic busy, res_valid, pass, go, next_vec, zero, mis;
  logic [N_IN:0] err_cnt;
  logic [2**N_IN-1:0] fail_map;
  assign go = st == ST_IDLE && bus.start && !bus.abort;
  assign next_vec = st == ST_SAMPLE && vec != '0 && !bus.abort;
  assign mis = bus.dut_f != exp_xnor(8'(vec));
  settle_timer u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(go || next_vec),
    .en(st == ST_SETTLE),
    .load_val(8'(SETTLE_CYCLES - 1)),
    .zero(zero)
  );
  // abort outranks every state action; results other than res_valid are left as they were
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      vec <= '0;
      busy <= 1'b0;
      res_valid <= 1'b0;
      pass <= 1'b0;
      err_cnt <= '0;
      fail_map <= '0;
    end else if (bus.abort && st != ST_IDLE) begin
      st <= ST_IDLE;
      vec <= '0;
      busy <= 1'b0;
      res_valid <= 1'b0;
    end else case (st)
      ST_IDLE: if (go) begin
        st <= ST_SETTLE;
        vec <= '1;
        busy <= 1'b1;
        err_cnt <= '0;
        fail_map <= '0;
        res_valid <= 1'b0;
        pass <= 1'b0;
      end
      ST_SETTLE: if (zero) st <= ST_SAMPLE;
      ST_SAMPLE: begin
        if (mis) begin
          err_cnt <= err_cnt + E_ONE;
          fail_map[vec] <= 1'b1;
        end
        if (vec == '0) begin
          st <= ST_DONE;
          busy <= 1'b0;
        end else begin
          vec <= vec - V_ONE;
          st <= ST_SETTLE;
        end
      end
      default: begin
        st <= ST_IDLE;
        res_valid <= 1'b1;
        pass <= err_cnt == '0;
      end
    endcase
  assign bus.dut_vec = vec;
  assign bus.busy = busy;
  assign bus.done = st == ST_DONE;
  assign bus.res_valid = res_valid;
  assign bus.pass = pass;
  assign bus.err_cnt = err_cnt;
  assign bus.fail_map = fail_map;
endmodule

// File: tb/tb_xnor_sweep_ctrl.sv
// tb_xnor_sweep_ctrl: randomized scoreboard bench for the XNOR sweep controller
module tb_xnor_sweep_ctrl;
  localparam int N = 3;
  localparam int S = 4;
  localparam int NV = 2 ** N;
  localparam int SWEEP = NV * (S + 1);
  typedef struct {
    logic [N:0] err;
    logic [NV-1:0] map;
    logic pass;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int mode = 0;
  logic [NV-1:0] mask = '0;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  xnor_sweep_if #(.N_IN(N)) bus ();
  xnor_sweep_ctrl #(.N_IN(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic logic ref_xnor(int v);
    return ($countones(v) % 2) == 0;
  endfunction

  // mode 0: healthy datapath with optional per-vector flips; 1: stuck-at-0; 2: stuck-at-1; 3: random flips
  function automatic logic model_f(int m, logic [NV-1:0] msk, int v);
    return m == 1 ? 1'b0 : m == 2 ? 1'b1 : ref_xnor(v) ^ msk[v];
  endfunction

  assign bus.dut_f = model_f(mode, mask, int'(bus.dut_vec));

  function automatic exp_t predict(int m, logic [NV-1:0] msk);
    exp_t e;
    e.err = '0;
    e.map = '0;
    for (int i = 0; i < NV; i++)
      if (model_f(m, msk, i) != ref_xnor(i)) begin
        e.map[i] = 1'b1;
        e.err = e.err + 1'b1;
      end
    e.pass = e.err == 0;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic prev_busy = 1'b0;
  logic [N-1:0] cur = '0;
  int run = 0;
  int lat = 0;
  int since_done = 0;
  logic pend = 1'b0;
  logic start_at_done = 1'b0;
  exp_t pend_e;
  exp_t got_e;

  always @(negedge clk) begin
    if (pend) begin
      chk("res_valid", 32'(bus.res_valid), 1);
      chk("pass", 32'(bus.pass), 32'(pend_e.pass));
      pend = 1'b0;
    end
    if (bus.busy && !prev_busy) begin
      chk("first_vec", 32'(bus.dut_vec), NV - 1);
      if (start_at_done) chk("idle_gap", since_done, 1);
      start_at_done = 1'b0;
      cur = bus.dut_vec;
      run = 1;
      lat = 1;
    end else if (bus.busy) begin
      lat++;
      if (bus.dut_vec == cur) run++;
      else begin
        chk("hold", run, S + 1);
        chk("step", 32'(bus.dut_vec), 32'(cur) - 1);
        cur = bus.dut_vec;
        run = 1;
      end
    end else if (prev_busy && bus.done) begin
      chk("hold_last", run, S + 1);
      chk("last_vec", 32'(cur), 0);
    end
    if (bus.done) begin
      chk("latency", lat, SWEEP);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done pulse with no sweep expected");
      end else begin
        got_e = sbq.pop_front();
        chk("err_cnt", 32'(bus.err_cnt), 32'(got_e.err));
        chk("fail_map", 32'(bus.fail_map), 32'(got_e.map));
        pend_e = got_e;
        pend = 1'b1;
      end
      since_done = 0;
      start_at_done = bus.start;
    end else if (!bus.busy) since_done++;
    prev_busy = bus.busy;
  end

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !bus.busy && !bus.done) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d sweeps still pending after %0d cycles", sbq.size(), budget);
  endtask

  task automatic sweep(int m, logic [NV-1:0] msk, bit repulse);
    mode = m;
    mask = msk;
    sbq.push_back(predict(m, msk));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (repulse) begin
      repeat (20) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_drain(200);
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_vec"}, 32'(bus.dut_vec), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
    chk({tag, "_fail_map"}, 32'(bus.fail_map), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    sweep(0, '0, 1'b0);
    sweep(1, '0, 1'b0);
    sweep(2, '0, 1'b0);
    sweep(0, '0, 1'b1);
    for (int k = 0; k < 4; k++) sweep(3, NV'($urandom), 1'($urandom_range(0, 1)));
    mode = 0;
    sbq.push_back(predict(0, '0));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    bus.abort = 1'b1;
    void'(sbq.pop_back());
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_vec", 32'(bus.dut_vec), 0);
    chk("abort_res_valid", 32'(bus.res_valid), 0);
    chk("abort_done", 32'(bus.done), 0);
    repeat (60) @(negedge clk);
    sweep(0, '0, 1'b0);
    mode = 3;
    mask = NV'($urandom);
    for (int t = 0; t < 100; t += SWEEP + 2) sbq.push_back(predict(mode, mask));
    bus.start = 1'b1;
    repeat (100) @(negedge clk);
    bus.start = 1'b0;
    wait_drain(300);
    @(negedge clk);
    mode = 0;
    sbq.push_back(predict(0, '0));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    void'(sbq.pop_back());
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_vec", 32'(bus.dut_vec), 0);
    sweep(0, '0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
